// File: rtl/seg_scan_capture_pkg.sv
// +--------------------------------------------------------------------------+
// | seg_scan_capture_pkg : scan-bus encodings shared with the display driver |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package seg_scan_capture_pkg;

  localparam int NUM_SLOTS = 8;

  // Active-low segment patterns, bit7 = dp
  localparam logic [7:0] SEG_0     = 8'b1100_0000;
  localparam logic [7:0] SEG_1     = 8'b1111_1001;
  localparam logic [7:0] SEG_2     = 8'b1010_0100;
  localparam logic [7:0] SEG_3     = 8'b1011_0000;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b1001_0010;
  localparam logic [7:0] SEG_6     = 8'b1000_0010;
  localparam logic [7:0] SEG_7     = 8'b1111_1000;
  localparam logic [7:0] SEG_8     = 8'b1000_0000;
  localparam logic [7:0] SEG_9     = 8'b1001_0000;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_PAT [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                          SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

  localparam logic [7:0] SEL_SLOT0 = 8'b0111_1111;
  localparam logic [7:0] SEL_SLOT1 = 8'b1011_1111;
  localparam logic [7:0] SEL_SLOT2 = 8'b1101_1111;
  localparam logic [7:0] SEL_SLOT3 = 8'b1110_1111;
  localparam logic [7:0] SEL_SLOT4 = 8'b1111_0111;
  localparam logic [7:0] SEL_SLOT5 = 8'b1111_1011;
  localparam logic [7:0] SEL_SLOT6 = 8'b1111_1101;
  localparam logic [7:0] SEL_SLOT7 = 8'b1111_1110;
  localparam logic [7:0] SEL_NONE  = 8'hFF;

  localparam logic [7:0] SEL_SLOT [NUM_SLOTS] = '{SEL_SLOT0, SEL_SLOT1, SEL_SLOT2, SEL_SLOT3,
                                                  SEL_SLOT4, SEL_SLOT5, SEL_SLOT6, SEL_SLOT7};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decode.sv
// +--------------------------------------------------------------------------+
// | seg_pattern_decode : 7-segment pattern -> BCD, unknown patterns flagged  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg_pattern_decode
  import seg_scan_capture_pkg::*;
(
  input  logic [7:0] i_pattern,
  output logic [3:0] o_bcd,
  output logic       o_err
);

  always_comb begin
    o_bcd = 4'hF;
    o_err = 1'b1;
    for (int d = 0; d < 10; d++) begin
      if (i_pattern == SEG_PAT[d]) begin
        o_bcd = 4'(d);
        o_err = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_capture.sv
// +--------------------------------------------------------------------------+
// | seg_scan_capture : samples the 8-digit scan bus, publishes whole frames  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
  parameter int STABLE_CNT    = 1,
  parameter int FRAME_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_com,
  input  logic [7:0]  seg_data,
  output logic [31:0] digits,
  output logic [7:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam int c_RUN_W = $clog2(STABLE_CNT + 1);
  localparam int c_TMO_W = $clog2(FRAME_TIMEOUT + 1);

  logic [7:0]         r_com, r_data, r_com_d, r_data_d;
  logic [c_RUN_W-1:0] r_run;
  logic [c_TMO_W-1:0] r_tmo;
  state_t             r_state;
  logic [2:0]         r_expected;
  logic [31:0]        r_sh_dig;
  logic [7:0]         r_sh_err;

  logic               w_differs, w_reached, w_accept;
  logic [c_RUN_W-1:0] w_run_next;
  logic [c_TMO_W-1:0] w_tmo_next;
  logic               w_slot_hit, w_bus_err;
  logic [2:0]         w_slot;
  logic [3:0]         w_bcd;
  logic               w_derr;
  logic [31:0]        w_sh_dig;
  logic [7:0]         w_sh_err;

  seg_pattern_decode u_decode (
    .i_pattern (r_data),
    .o_bcd     (w_bcd),
    .o_err     (w_derr)
  );

  // Run length of the current registered pair; an accept fires once, when it first hits STABLE_CNT
  assign w_differs  = {r_com, r_data} != {r_com_d, r_data_d};
  assign w_run_next = w_differs ? c_RUN_W'(1)
                    : (r_run == c_RUN_W'(STABLE_CNT)) ? r_run : r_run + 1'b1;
  assign w_reached  = (w_run_next == c_RUN_W'(STABLE_CNT)) &&
                      (w_differs || (r_run != c_RUN_W'(STABLE_CNT)));
  assign w_accept   = w_reached && w_slot_hit;
  assign w_bus_err  = !w_slot_hit && (r_com != SEL_NONE);
  assign w_tmo_next = r_tmo + 1'b1;

  always_comb begin
    w_slot_hit = 1'b0;
    w_slot     = 3'd0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (r_com == SEL_SLOT[s]) begin
        w_slot_hit = 1'b1;
        w_slot     = 3'(s);
      end
    end
  end

  // Shadow with the current slot merged in, so slot 7 can be published on its own accept
  always_comb begin
    w_sh_dig = r_sh_dig;
    w_sh_err = r_sh_err;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_slot == 3'(s)) begin
        w_sh_dig[31-4*s -: 4] = w_bcd;
        w_sh_err[7-s]         = w_derr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_com       <= SEL_NONE;
      r_data      <= SEG_BLANK;
      r_com_d     <= SEL_NONE;
      r_data_d    <= SEG_BLANK;
      r_run       <= '0;
      r_tmo       <= '0;
      r_state     <= IDLE;
      r_expected  <= 3'd0;
      r_sh_dig    <= 32'd0;
      r_sh_err    <= 8'd0;
      digits      <= 32'd0;
      digit_err   <= 8'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_com       <= seg_com;
      r_data      <= seg_data;
      r_com_d     <= r_com;
      r_data_d    <= r_data;
      r_run       <= w_run_next;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept && (w_slot == 3'd0)) begin
            r_sh_dig   <= {w_bcd, 28'd0};
            r_sh_err   <= {w_derr, 7'd0};
            r_expected <= 3'd1;
            r_tmo      <= '0;
            r_state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (w_bus_err) begin
            frame_err  <= 1'b1;
            r_state    <= IDLE;
            r_expected <= 3'd0;
            r_tmo      <= '0;
            r_sh_dig   <= 32'd0;
            r_sh_err   <= 8'd0;
          end else if (w_accept) begin
            r_tmo <= '0;
            if (w_slot == r_expected) begin
              r_sh_dig   <= w_sh_dig;
              r_sh_err   <= w_sh_err;
              r_expected <= r_expected + 3'd1;
              if (w_slot == 3'd7) begin
                digits      <= w_sh_dig;
                digit_err   <= w_sh_err;
                frame_valid <= 1'b1;
                r_state     <= IDLE;
              end
            end else if (w_slot == 3'd0) begin
              frame_err  <= 1'b1;
              r_sh_dig   <= {w_bcd, 28'd0};
              r_sh_err   <= {w_derr, 7'd0};
              r_expected <= 3'd1;
            end else begin
              frame_err  <= 1'b1;
              r_state    <= IDLE;
              r_expected <= 3'd0;
              r_sh_dig   <= 32'd0;
              r_sh_err   <= 8'd0;
            end
          end else if (w_tmo_next == c_TMO_W'(FRAME_TIMEOUT)) begin
            frame_err  <= 1'b1;
            r_state    <= IDLE;
            r_expected <= 3'd0;
            r_tmo      <= '0;
            r_sh_dig   <= 32'd0;
            r_sh_err   <= 8'd0;
          end else begin
            r_tmo <= w_tmo_next;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
